// File: rtl/m_bitmap_header_gen_if.sv
// Bus between the SD controller and the BMP header generator, including the
// sector-buffer write port the generator drives.
interface m_bitmap_header_gen_if #(
  parameter int ADDR_LEN = 9
);
  logic                GenBMPEn;
  logic [15:0]         PixWidth;
  logic [15:0]         PixHeight;
  logic                GenBMPComplite;
  logic                GenBMPFail;
  logic [31:0]         FileSize;
  logic [31:0]         ImageSize;
  logic                DB_WE;
  logic [ADDR_LEN:0]   DB_write_addr;
  logic [31:0]         DB_write_data;

  modport master (
    output GenBMPEn, PixWidth, PixHeight,
    input  GenBMPComplite, GenBMPFail, FileSize, ImageSize,
    input  DB_WE, DB_write_addr, DB_write_data
  );

  modport slave (
    input  GenBMPEn, PixWidth, PixHeight,
    output GenBMPComplite, GenBMPFail, FileSize, ImageSize,
    output DB_WE, DB_write_addr, DB_write_data
  );
endinterface

// File: rtl/m_bitmap_header_gen.sv
// Builds a 54-byte 24 bpp BMP header and writes it as 14 little-endian words.
// Define BMP_SIZE_CHECK_EN to also reject files of 0xFFFFFF bytes or more.
module m_bitmap_header_gen #(
  parameter int ADDR_LEN = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  m_bitmap_header_gen_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_STRIDE   = 3'd1,
    S_MUL      = 3'd2,
    S_CHECK    = 3'd3,
    S_WRITE    = 3'd4,
    S_COMPLITE = 3'd5,
    S_FAIL     = 3'd6
  } state_t;

  // Word k of the header; byte n of the file sits at bits [8(n%4)+7 : 8(n%4)].
  function automatic logic [31:0] header_word(input logic [3:0]  k,
                                              input logic [31:0] fs,
                                              input logic [31:0] is,
                                              input logic [15:0] w,
                                              input logic [15:0] h);
    logic [31:0] word;
    case (k)
      4'd0:    word = {fs[15:0], 8'h4D, 8'h42};
      4'd1:    word = {16'h0000, fs[31:16]};
      4'd2:    word = 32'h0036_0000;
      4'd3:    word = 32'h0028_0000;
      4'd4:    word = {w, 16'h0000};
      4'd5:    word = {h, 16'h0000};
      4'd6:    word = 32'h0001_0000;
      4'd7:    word = 32'h0000_0018;
      4'd8:    word = {is[15:0], 16'h0000};
      4'd9:    word = {16'h0B13, is[31:16]};
      4'd10:   word = 32'h0B13_0000;
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  state_t            state_q, state_d;
  logic [15:0]       w_q, w_d, h_q, h_d;
  logic [33:0]       mcand_q, mcand_d, acc_q, acc_d;
  logic [15:0]       mplier_q, mplier_d;
  logic [3:0]        cnt_q, cnt_d, word_q, word_d;
  logic              complite_q, complite_d, fail_q, fail_d, we_q, we_d;
  logic [31:0]       fs_q, fs_d, is_q, is_d, data_q, data_d;
  logic [ADDR_LEN:0] addr_q, addr_d;

  logic [17:0]       stride_s;
  logic [31:0]       fs_s;
  logic              size_bad_s;

  assign stride_s = (({2'b00, w_q} << 1) + {2'b00, w_q} + 18'd3) & 18'h3FFFC;
  assign fs_s     = acc_q[31:0] + 32'd54;

`ifdef BMP_SIZE_CHECK_EN
  logic [34:0] full_size_s;
  assign full_size_s = {1'b0, acc_q} + 35'd54;
  assign size_bad_s  = (full_size_s >= 35'h0_00FF_FFFF);
`else
  logic [1:0] acc_hi_unused_s;
  assign acc_hi_unused_s = acc_q[33:32];
  assign size_bad_s      = 1'b0;
`endif

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    h_d        = h_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    complite_d = complite_q;
    fail_d     = fail_q;
    we_d       = 1'b0;
    fs_d       = fs_q;
    is_d       = is_q;
    data_d     = data_q;
    addr_d     = addr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.GenBMPEn) begin
          w_d     = bus.PixWidth;
          h_d     = bus.PixHeight;
          state_d = S_STRIDE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STRIDE: begin
        mcand_d  = {16'h0000, stride_s};
        mplier_d = h_q;
        acc_d    = 34'd0;
        cnt_d    = 4'd0;
        state_d  = S_MUL;
      end
      S_MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end else begin
          acc_d = acc_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_MUL;
        end
      end
      S_CHECK: begin
        fs_d = fs_s;
        is_d = acc_q[31:0];
        if ((w_q == 16'd0) || (h_q == 16'd0) || size_bad_s) begin
          fail_d  = 1'b1;
          state_d = S_FAIL;
        end else begin
          // Word 0 goes out on the same edge that leaves CHECK.
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = header_word(4'd0, fs_s, acc_q[31:0], w_q, h_q);
          word_d  = 4'd1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (word_q <= 4'd13) begin
          we_d   = 1'b1;
          addr_d = (ADDR_LEN + 1)'({word_q, 2'b00});
          data_d = header_word(word_q, fs_q, is_q, w_q, h_q);
          word_d = word_q + 4'd1;
        end else begin
          complite_d = 1'b1;
          state_d    = S_COMPLITE;
        end
      end
      S_COMPLITE: begin
        if (!bus.GenBMPEn) begin
          complite_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d    = S_COMPLITE;
        end
      end
      S_FAIL: begin
        if (!bus.GenBMPEn) begin
          fail_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_FAIL;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      w_q        <= 16'd0;
      h_q        <= 16'd0;
      mcand_q    <= 34'd0;
      acc_q      <= 34'd0;
      mplier_q   <= 16'd0;
      cnt_q      <= 4'd0;
      word_q     <= 4'd0;
      complite_q <= 1'b0;
      fail_q     <= 1'b0;
      we_q       <= 1'b0;
      fs_q       <= 32'd0;
      is_q       <= 32'd0;
      data_q     <= 32'd0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      h_q        <= h_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      complite_q <= complite_d;
      fail_q     <= fail_d;
      we_q       <= we_d;
      fs_q       <= fs_d;
      is_q       <= is_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
    end
  end

  assign bus.GenBMPComplite = complite_q;
  assign bus.GenBMPFail     = fail_q;
  assign bus.FileSize       = fs_q;
  assign bus.ImageSize      = is_q;
  assign bus.DB_WE          = we_q;
  assign bus.DB_write_addr  = addr_q;
  assign bus.DB_write_data  = data_q;

endmodule
